fetch_unit: RTL

Instruction fetch stage that generates the word-addressed program counter driving the `icache` PC input. It captures the returned instruction, paired with its PC, into a small fetch queue. The queue is drained by decode through a valid/ready handshake. Branch/jump redirects from execute flush the queue and restart fetch at a new PC.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 75 +++++++
 rtl/fetch_unit.sv | 84 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults: the {pc, instr} entry handed to decode
// and the default PC width, queue depth and reset PC.
package fetch_pkg;

    localparam int unsigned FETCH_WIDTH = 32;
    localparam int unsigned FETCH_DEPTH = 4;
    localparam logic [FETCH_WIDTH-1:0] FETCH_RESET_PC = '0;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0] pc;
        logic [FETCH_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc, instr} fetch entries with a flush that empties it in one edge.
// Flush wins over enqueue and dequeue in the same cycle.
module fetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       enq_i,
    input  logic [WIDTH-1:0]           enq_pc_i,
    input  logic [WIDTH-1:0]           enq_instr_i,
    input  logic                       deq_i,
    output logic [WIDTH-1:0]           head_pc_o,
    output logic [WIDTH-1:0]           head_instr_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [WIDTH-1:0] pc_mem_d    [DEPTH];
    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [WIDTH-1:0] instr_mem_d [DEPTH];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_i) begin
                pc_mem_d[wr_ptr_q]    = enq_pc_i;
                instr_mem_d[wr_ptr_q] = enq_instr_i;
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end
            if (deq_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(enq_i) - CW'(deq_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: word-addressed PC generation, in-flight tracking against a
// one-cycle icache, credit-checked fetch queue and redirect handling.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = FETCH_WIDTH,
    parameter int unsigned      DEPTH    = FETCH_DEPTH,
    parameter logic [WIDTH-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] instruction,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic [CW-1:0]    count;
    logic [CW:0]      occupancy;
    logic             deq;
    logic             issue;
    logic             enq;

    assign out_valid = (count != '0);
    assign deq       = out_valid && out_ready;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        // Slots already owed to the queue plus the one returning now; deq frees one this edge.
        occupancy     = {1'b0, count} + (CW + 1)'(inflight_q) - (CW + 1)'(deq);
        issue         = !redirect_valid && (occupancy < DEPTH_C);
        enq           = inflight_q && !redirect_valid;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d          = pc_q + WIDTH'(1);
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign PC = pc_q;

    fetch_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i        (CLK),
        .rst_ni       (RST),
        .flush_i      (redirect_valid),
        .enq_i        (enq),
        .enq_pc_i     (inflight_pc_q),
        .enq_instr_i  (instruction),
        .deq_i        (deq),
        .head_pc_o    (out_pc),
        .head_instr_o (out_instr),
        .count_o      (count)
    );

endmodule
